instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//   Instruction fetch unit; reads the address held in the program counter.
//   Samples the PC value, runs a request/ack read against instruction ROM,
//   holds the returned word for the core with a valid/ready handshake, and pulses
//   pc_incr when the core accepts. Sits between pc, ROM and the decode/execute stage.
// PARAMETERS
//   ADDR_W   16  PC / ROM address width
//   DATA_W   16  instruction word width
//   CNT_W    16  width of retired-instruction counter
// PORTS
//   clk          in   1       single clock, rising edge
//   reset        in   1       asynchronous, active-high; clears all state
//   pc_addr      in   ADDR_W  current PC value (pc.out)
//   flush        in   1       PC is being loaded (jump) this cycle
//   pc_incr      out  1       advance PC; drives pc.incr
//   rom_req      out  1       ROM read request
//   rom_addr     out  ADDR_W  ROM read address
//   rom_ack      in   1       ROM read complete; rom_data valid this cycle
//   rom_data     in   DATA_W  ROM read data
//   instr_out    out  DATA_W  fetched instruction
//   instr_valid  out  1       instr_out holds a valid instruction
//   instr_ready  in   1       core accepts instr_out this cycle
//   instr_count  out  CNT_W   instructions retired, wraps
// BEHAVIOUR
//   - Reset (async): state IDLE; rom_req, rom_addr, pc_incr, instr_out,
//     instr_valid, instr_count, discard flag = 0. Any ROM transaction in flight
//     is abandoned; the ROM tolerates a dropped request.
//   - FSM states IDLE, REQ, HOLD; all outputs registered except pc_incr.
//   - IDLE: latch pc_addr into addr_q; go REQ next edge.
//   - REQ: rom_req=1, rom_addr=addr_q; both stable until rom_ack.
//     rom_ack in the first REQ cycle is legal (zero-wait ROM).
//     On rom_ack: if discard=0, ir<=rom_data, go HOLD; if discard=1, drop data,
//     clear discard, go IDLE.
//     flush during REQ: request is not withdrawn; set discard.
//     flush and rom_ack in the same cycle: data dropped, go IDLE.
//   - HOLD: instr_valid=1, instr_out stable.
//     instr_ready & ~flush: pc_incr=1 for this cycle, instr_count+1, go IDLE.
//     instr_ready & flush: accepted jump; instr_count+1, pc_incr=0, go IDLE.
//     ~instr_ready & flush: instruction dropped, no count, go IDLE.
//     instr_valid deasserts on the edge leaving HOLD.
//   - pc_incr = (state==HOLD) & instr_ready & ~flush; combinational, one-cycle pulse.
//   - The following IDLE cycle samples the already-updated PC, so there are no
//     stale addresses.
//   - Throughput: min 3 cycles per instruction (IDLE, REQ, HOLD) with zero-wait ROM.
//   - instr_count wraps from 2^CNT_W-1 to 0, no saturation.
//   - rom_addr is modulo ADDR_W and wraps with the PC; no range check.
// STRUCTURE
//   - hack_pkg: ADDR_W/DATA_W defaults, FSM state encodings (2 bits),
//     RESET_VECTOR = 0.
//   - No sub-module. ir and addr_q are local flops with async reset;
//     the existing register block has no reset port and is not reused.
// TESTING
//   1. Reset, zero-wait ROM with ROM[0]=16'h0007, ready=1 -> rom_req @cyc1
//      addr 0, instr_valid @cyc2 data 0007, pc_incr pulse @cyc2, count=1.
//   2. 3-cycle-wait ROM, ready=0 for 4 cycles -> rom_addr/rom_req stable until ack;
//      instr_out held; no pc_incr until ready.
//   3. flush in REQ cycle 1 with ack 2 cycles later -> data discarded, no valid;
//      next fetch uses new pc_addr 16'h0100.
//   4. HOLD with instr_ready & flush -> pc_incr=0, count+1, next rom_addr = jump target.
//   5. Reset asserted mid-REQ (async, between edges) -> rom_req drops immediately,
//      instr_valid=0, count=0; after release, fetch restarts at pc_addr.
//   6. Preload count to 16'hFFFF, accept one instruction -> count=0;
//      pc_addr 16'hFFFF fetch -> rom_addr 16'hFFFF.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: default widths,
// fetch FSM state encoding and the address used out of reset.
package instr_fetch_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_CNT_W  = 16;

    localparam int RESET_VECTOR = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of the PC, ROM and core-side signals of the fetch unit.
// The master modport is the fetch unit itself; the slave modport is
// whatever surrounds it (PC, ROM, decode stage).
interface instr_fetch_if
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
);

    logic [ADDR_W-1:0] pc_addr;
    logic              flush;
    logic              pc_incr;
    logic              rom_req;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_ack;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] instr_out;
    logic              instr_valid;
    logic              instr_ready;
    logic [CNT_W-1:0]  instr_count;

    modport master (
        input  pc_addr, flush, rom_ack, rom_data, instr_ready,
        output pc_incr, rom_req, rom_addr, instr_out, instr_valid, instr_count
    );

    modport slave (
        output pc_addr, flush, rom_ack, rom_data, instr_ready,
        input  pc_incr, rom_req, rom_addr, instr_out, instr_valid, instr_count
    );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit. Samples the PC, reads the ROM with a req/ack
// handshake, offers the word to the core with valid/ready and pulses
// pc_incr when the core takes it. A jump (flush) while the ROM read is
// outstanding lets the read finish but throws its data away.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
)
(
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] ir_q;
    logic [CNT_W-1:0]  count_q;
    logic              discard_q;
    logic              rom_req_q;
    logic              valid_q;
    logic              pc_incr;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: one sampling cycle, wait for the ROM, then wait for the core.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (bus.rom_ack) begin
                    state_d = (discard_q || bus.flush) ? IDLE : HOLD;
                end
            end
            HOLD: begin
                if (bus.instr_ready || bus.flush) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs follow the state being entered, so rom_req and
    // instr_valid line up exactly with REQ and HOLD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_req_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            rom_req_q <= (state_d == REQ);
            valid_q   <= (state_d == HOLD);
        end
    end

    // Fetch address, captured only in IDLE so it stays put for the whole read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= ADDR_W'(RESET_VECTOR);
        end else if (state_q == IDLE) begin
            addr_q <= bus.pc_addr;
        end
    end

    // Remember a jump seen while the ROM read was outstanding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            discard_q <= 1'b0;
        end else if (state_q == REQ) begin
            if (bus.rom_ack) begin
                discard_q <= 1'b0;
            end else if (bus.flush) begin
                discard_q <= 1'b1;
            end
        end
    end

    // Instruction register: load only ROM data that is still wanted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q <= '0;
        end else if (state_q == REQ && bus.rom_ack && !discard_q && !bus.flush) begin
            ir_q <= bus.rom_data;
        end
    end

    // Retired-instruction counter; a taken jump still retires the word on offer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (state_q == HOLD && bus.instr_ready) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    // Combinational PC advance, suppressed when the PC is loading a jump.
    always_comb begin
        pc_incr = (state_q == HOLD) && bus.instr_ready && !bus.flush;
    end

    assign bus.pc_incr     = pc_incr;
    assign bus.rom_req     = rom_req_q;
    assign bus.rom_addr    = addr_q;
    assign bus.instr_out   = ir_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr_count = count_q;

endmodule
